mc_ctrl: RTL and testbench

//  Multi-cycle control FSM that sequences the MIPS-lite datapath around the npc unit, PC register, IR, ALU, GRF and DM.

---
 rtl/mc_ctrl.sv | 145 ++++++++++++++
 tb/tb_mc_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite control FSM: sequences fetch/decode/execute/memory/writeback,
// drives npc selects and datapath controls, and counts retired instructions.
module mc_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter bit MEM_WAIT_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        dayuling,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        ifbeq,
  output logic        ifbgtz,
  output logic        j,
  output logic        jal,
  output logic        jr,
  output logic        reg_we,
  output logic [1:0]  regdst,
  output logic [1:0]  memtoreg,
  output logic        alusrc,
  output logic [2:0]  aluop,
  output logic        extop,
  output logic        mem_we,
  output logic        halt,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      r_state;
  logic [31:0] r_instr_cnt;

  logic w_rtype, w_addu, w_subu, w_nop, w_jr, w_ori, w_lui, w_lw, w_sw;
  logic w_beq, w_bgtz, w_j, w_jal, w_illegal, w_active, w_ready;
  logic w_unused;

  // The branch outcome is resolved inside npc; the FSM timing does not depend on it.
  assign w_unused = zero ^ dayuling;

  assign w_rtype   = (opcode == 6'b000000);
  assign w_addu    = w_rtype && (funct == 6'b100001);
  assign w_subu    = w_rtype && (funct == 6'b100011);
  assign w_nop     = w_rtype && (funct == 6'b000000);
  assign w_jr      = w_rtype && (funct == 6'b001000);
  assign w_ori     = (opcode == 6'b001101);
  assign w_lui     = (opcode == 6'b001111);
  assign w_lw      = (opcode == 6'b100011);
  assign w_sw      = (opcode == 6'b101011);
  assign w_beq     = (opcode == 6'b000100);
  assign w_bgtz    = (opcode == 6'b000111);
  assign w_j       = (opcode == 6'b000010);
  assign w_jal     = (opcode == 6'b000011);
  assign w_illegal = !(w_addu || w_subu || w_nop || w_jr || w_ori || w_lui || w_lw ||
                       w_sw || w_beq || w_bgtz || w_j || w_jal);
  assign w_ready   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign w_active  = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                     (r_state == S_MEM) || (r_state == S_WB);

  always_comb begin
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    halt     = 1'b0;
    ifbeq    = 1'b0;
    ifbgtz   = 1'b0;
    j        = 1'b0;
    jal      = 1'b0;
    jr       = 1'b0;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    alusrc   = 1'b0;
    aluop    = 3'b000;
    extop    = 1'b0;
    case (r_state)
      S_FETCH:  ir_we = 1'b1;
      S_DECODE: pc_we = w_j || w_jr || w_nop || (w_illegal && !HALT_ON_ILLEGAL);
      S_EXEC:   pc_we = w_beq || w_bgtz;
      S_MEM: begin
        mem_we = w_sw;
        pc_we  = w_sw && w_ready;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
      end
      S_HALT:   halt = 1'b1;
      default:  ;
    endcase
    // Selects and ALU controls stay stable for the whole instruction after decode.
    if (w_active) begin
      ifbeq    = w_beq;
      ifbgtz   = w_bgtz;
      j        = w_j;
      jal      = w_jal;
      jr       = w_jr;
      regdst   = (w_addu || w_subu) ? 2'b01 : (w_jal ? 2'b10 : 2'b00);
      memtoreg = w_lw ? 2'b01 : (w_jal ? 2'b10 : 2'b00);
      alusrc   = w_ori || w_lui || w_lw || w_sw;
      extop    = w_lw || w_sw;
      if (w_subu || w_beq || w_bgtz) aluop = 3'b001;
      else if (w_ori)                aluop = 3'b010;
      else if (w_lui)                aluop = 3'b011;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_instr_cnt <= 32'd0;
    end else begin
      if (pc_we) r_instr_cnt <= r_instr_cnt + 32'd1;
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_j || w_jr || w_nop)    r_state <= S_FETCH;
          else if (w_jal)              r_state <= S_WB;
          else if (w_illegal)          r_state <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          else                         r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_beq || w_bgtz)         r_state <= S_FETCH;
          else if (w_lw || w_sw)       r_state <= S_MEM;
          else                         r_state <= S_WB;
        end
        S_MEM: begin
          if (w_ready)                 r_state <= w_sw ? S_FETCH : S_WB;
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed instruction table, randomized instruction
// stream against an instruction-level model, plus halt and mid-instruction reset sequences.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, dayuling, mem_ready;
  logic        ir_we, pc_we, ifbeq, ifbgtz, j, jal, jr, reg_we;
  logic [1:0]  regdst, memtoreg;
  logic        alusrc;
  logic [2:0]  aluop;
  logic        extop, mem_we, halt;
  logic [31:0] instr_cnt;
  logic [18:0] act;

  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.HALT_ON_ILLEGAL(1'b1), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .dayuling(dayuling), .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we),
    .ifbeq(ifbeq), .ifbgtz(ifbgtz), .j(j), .jal(jal), .jr(jr), .reg_we(reg_we),
    .regdst(regdst), .memtoreg(memtoreg), .alusrc(alusrc), .aluop(aluop),
    .extop(extop), .mem_we(mem_we), .halt(halt), .instr_cnt(instr_cnt)
  );

  assign act = {ir_we, pc_we, ifbeq, ifbgtz, j, jal, jr, reg_we, regdst, memtoreg,
                alusrc, aluop, extop, mem_we, halt};

  // Instruction record: stimulus plus the controls expected for its whole lifetime.
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         nwait;
    int         ncyc;
    logic [4:0] sel;      // {beq, bgtz, j, jal, jr}
    logic       regwe;
    logic       memwe;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrc;
    logic [2:0] aluop;
    logic       extop;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t model(input logic [5:0] op, input logic [5:0] fn, input int nw);
    vec_t v;
    v = '{default: 0};
    v.op = op;
    v.fn = fn;
    v.ncyc = 2;
    case (op)
      6'h00: begin
        if (fn == 6'h21) begin v.ncyc = 4; v.regwe = 1; v.regdst = 2'b01; end
        else if (fn == 6'h23) begin v.ncyc = 4; v.regwe = 1; v.regdst = 2'b01; v.aluop = 3'b001; end
        else if (fn == 6'h08) v.sel = 5'b00001;
      end
      6'h0d: begin v.ncyc = 4; v.regwe = 1; v.alusrc = 1; v.aluop = 3'b010; end
      6'h0f: begin v.ncyc = 4; v.regwe = 1; v.alusrc = 1; v.aluop = 3'b011; end
      6'h23: begin
        v.nwait = nw; v.ncyc = 5 + nw; v.regwe = 1; v.memtoreg = 2'b01;
        v.alusrc = 1; v.extop = 1;
      end
      6'h2b: begin v.nwait = nw; v.ncyc = 4 + nw; v.memwe = 1; v.alusrc = 1; v.extop = 1; end
      6'h04: begin v.ncyc = 3; v.sel = 5'b10000; v.aluop = 3'b001; end
      6'h07: begin v.ncyc = 3; v.sel = 5'b01000; v.aluop = 3'b001; end
      6'h02: v.sel = 5'b00100;
      6'h03: begin v.ncyc = 3; v.sel = 5'b00010; v.regwe = 1; v.regdst = 2'b10; v.memtoreg = 2'b10; end
      default: ;
    endcase
    return v;
  endfunction

  // Cycle 0 is FETCH; the last cycle retires; MEM (if any) starts at cycle 3.
  function automatic logic [18:0] exp_vec(input vec_t v, input int k);
    logic last;
    if (k == 0) return 19'h40000;
    last = (k == v.ncyc - 1);
    return {1'b0, last, v.sel, v.regwe && last, v.regdst, v.memtoreg, v.alusrc,
            v.aluop, v.extop, v.memwe && (k >= 3), 1'b0};
  endfunction

  task automatic check(input string nm, input int idx, input int cyc,
                       input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s idx=%0d cyc=%0d actual=%h expected=%h", nm, idx, cyc, a, e);
    end
  endtask

  task automatic drive_cycle(input vec_t v, input int k, input string nm, input int idx);
    if (k == 0) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
    end else begin
      opcode = v.op;
      funct  = v.fn;
    end
    zero     = 1'($urandom);
    dayuling = 1'($urandom);
    if (k >= 3 && k < 3 + v.nwait) mem_ready = 1'b0;
    else if (k == 3 + v.nwait)     mem_ready = 1'b1;
    else                           mem_ready = 1'($urandom);
    @(negedge clk);
    check(nm, idx, k, {13'd0, act}, {13'd0, exp_vec(v, k)});
  endtask

  task automatic run_instr(input vec_t v, input string nm, input int idx);
    for (int k = 0; k < v.ncyc; k++) begin
      drive_cycle(v, k, nm, idx);
      @(posedge clk); #1;
    end
    model_cnt++;
    check({nm, "_cnt"}, idx, v.ncyc, instr_cnt, model_cnt);
  endtask

  task automatic release_reset(input string nm);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check({nm, "_idle"}, 0, 0, {13'd0, act}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog idx=0 cyc=0 actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t v;
    int   sel;
    logic [5:0] rop, rfn;
    tbl[0]  = '{6'h00, 6'h21, 0, 4, 5'b00000, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0}; // addu
    tbl[1]  = '{6'h00, 6'h23, 0, 4, 5'b00000, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 3'b001, 1'b0}; // subu
    tbl[2]  = '{6'h0d, 6'h15, 0, 4, 5'b00000, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 3'b010, 1'b0}; // ori
    tbl[3]  = '{6'h0f, 6'h00, 0, 4, 5'b00000, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 3'b011, 1'b0}; // lui
    tbl[4]  = '{6'h04, 6'h00, 0, 3, 5'b10000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0}; // beq
    tbl[5]  = '{6'h04, 6'h2a, 0, 3, 5'b10000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0}; // beq
    tbl[6]  = '{6'h23, 6'h00, 3, 8, 5'b00000, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 3'b000, 1'b1}; // lw, 3 waits
    tbl[7]  = '{6'h23, 6'h00, 0, 5, 5'b00000, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 3'b000, 1'b1}; // lw
    tbl[8]  = '{6'h03, 6'h00, 0, 3, 5'b00010, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 3'b000, 1'b0}; // jal
    tbl[9]  = '{6'h00, 6'h08, 0, 2, 5'b00001, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0}; // jr
    tbl[10] = '{6'h2b, 6'h00, 0, 4, 5'b00000, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1}; // sw
    tbl[11] = '{6'h2b, 6'h00, 2, 6, 5'b00000, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1}; // sw, 2 waits
    tbl[12] = '{6'h07, 6'h00, 0, 3, 5'b01000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0}; // bgtz
    tbl[13] = '{6'h02, 6'h00, 0, 2, 5'b00100, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0}; // j

    reset = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; dayuling = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 0, 0, {13'd0, act}, 32'd0);
    check("reset_cnt", 0, 0, instr_cnt, 32'd0);
    release_reset("rel0");

    for (int i = 0; i < 14; i++) run_instr(tbl[i], "table", i);
    // nop: all-zero word
    run_instr('{6'h00, 6'h00, 0, 2, 5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0}, "nop", 0);

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 11));
      rfn = 6'($urandom);
      case (sel)
        0: begin rop = 6'h00; rfn = 6'h21; end
        1: begin rop = 6'h00; rfn = 6'h23; end
        2: rop = 6'h0d;
        3: rop = 6'h0f;
        4: rop = 6'h23;
        5: rop = 6'h2b;
        6: rop = 6'h04;
        7: rop = 6'h07;
        8: rop = 6'h02;
        9: rop = 6'h03;
        10: begin rop = 6'h00; rfn = 6'h08; end
        default: begin rop = 6'h00; rfn = 6'h00; end
      endcase
      v = model(rop, rfn, int'($urandom_range(0, 3)));
      run_instr(v, "rand", i);
    end

    // Illegal opcode: decode shows nothing, then HALT absorbs until reset.
    v = '{default: 0};
    v.op = 6'h3f; v.fn = 6'h12; v.ncyc = 40;
    drive_cycle(v, 0, "ill_fetch", 0);
    @(posedge clk); #1;
    opcode = 6'h3f; funct = 6'h12;
    @(negedge clk);
    check("ill_decode", 0, 1, {13'd0, act}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      opcode = 6'($urandom); funct = 6'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      check("halt_outs", c, c + 2, {13'd0, act}, 32'd1);
    end
    check("halt_cnt", 0, 0, instr_cnt, model_cnt);
    #2 reset = 1'b0;
    #1;
    check("halt_clear", 0, 0, {13'd0, act}, 32'd0);
    check("halt_rst_cnt", 0, 0, instr_cnt, 32'd0);
    model_cnt = 0;
    release_reset("rel1");
    run_instr(tbl[0], "post_halt", 0);

    // sw stalled in MEM, then reset mid-cycle.
    v = model(6'h2b, 6'h00, 5);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(v, k, "sw_abort", 0);
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    #2 reset = 1'b0;
    #1;
    check("sw_abort_outs", 0, 0, {13'd0, act}, 32'd0);
    check("sw_abort_cnt", 0, 0, instr_cnt, 32'd0);
    model_cnt = 0;
    release_reset("rel2");
    run_instr(tbl[1], "post_abort", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
